wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Writeback-side initiator for the 32x32 general-purpose register file. It owns the file's single write port: rd_o/datord_o/wren_o.
- Merges single-cycle ALU results and long-latency results (load/mul/div) onto that one port. Long-latency results are buffered in a small queue.
- Keeps a pending-register scoreboard so decode can stall on RAW/WAW hazards against outstanding long-latency ops.
- Sits between execute/memory stages and the register file in the Lagarto core.

Parameters:
- XLEN, 32, data width of results and register file.
- NREG, 32, number of architectural registers; register address width is log2(NREG)=5.
- QDEPTH, 2, entries in the long-latency result queue.
- STARVE_MAX, 4, consecutive cycles a queued result may lose arbitration before ALU is stalled.

Ports:
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- alu_valid_i  in  1  ALU result valid this cycle.
- alu_rd_i  in  5  ALU destination register.
- alu_data_i  in  XLEN  ALU result.
- wb_stall_o  out  1  ALU result not written this cycle; upstream must hold alu_* unchanged.
- slow_valid_i  in  1  long-latency result valid.
- slow_rd_i  in  5  long-latency destination register.
- slow_data_i  in  XLEN  long-latency result.
- slow_ready_o  out  1  queue can accept; transfer occurs when slow_valid_i & slow_ready_o.
- issue_i  in  1  long-latency op dispatched this cycle.
- issue_rd_i  in  5  destination of the dispatched op.
- dec_rs1_i  in  5  decode source 1 for hazard check.
- dec_rs2_i  in  5  decode source 2 for hazard check.
- dec_rd_i  in  5  decode destination for WAW check.
- hazard_o  out  1  decode must stall.
- rd_o  out  5  register-file write address.
- datord_o  out  XLEN  register-file write data.
- wren_o  out  1  register-file write enable.

Behaviour:
- Reset (rst_i=1 at a rising edge):
  - queue emptied, all pending bits cleared, starvation counter=0, force flag=0.
  - Outputs while rst_i=1: slow_ready_o=0, wb_stall_o=0, hazard_o=0, wren_o=0.
  - Reset mid-operation drops queued results silently.
- Arbitration is combinational each cycle, in priority order:
  - (a) force=1 and queue non-empty: queue head writes, wb_stall_o=1.
  - (b) alu_valid_i=1: ALU writes, wb_stall_o=0.
  - (c) queue non-empty: head writes (pop).
  - (d) otherwise wren_o=0, rd_o=0, datord_o=0.
- x0 writes: any write with rd=0 drives wren_o=0. The data is consumed (queue pop / ALU completes) but never written.
- wb_stall_o=0 whenever alu_valid_i=0.
- Queue:
  - FIFO of {rd, data}; slow_ready_o = (count<QDEPTH).
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Full: slow_ready_o=0 even if a pop occurs that cycle (no full-bypass).
  - Minimum latency slow input -> wren_o is 1 cycle. There is no same-cycle bypass.
- Starvation:
  - Counter increments each cycle the queue is non-empty and the head is not popped; it resets to 0 on any pop or when the queue is empty.
  - When counter==STARVE_MAX-1 and the head is again not popped, force is set for the next cycle. Force clears after one forced pop.
- Scoreboard pending[NREG]:
  - Set at the edge when issue_i=1 and issue_rd_i!=0.
  - Cleared at the edge the queue head with matching rd is popped.
  - Same register set and cleared in the same cycle: set wins.
  - issue_i to an already-pending register is illegal and must be flagged by a bench assertion; decode guarantees it never happens via hazard_o.
- hazard_o is combinational: (rs1!=0 & pending[rs1]) | (rs2!=0 & pending[rs2]) | (dec_rd!=0 & pending[dec_rd]).
- The scoreboard does not forward. A result is readable from the register file the cycle after wren_o.

Decomposition:
- Shared package/include lagarto_pkg: XLEN, REG_AW=5, NREG, wb entry struct {rd, data}, x0 constant.
- One sub-module, wb_fifo: parameterised QDEPTH synchronous FIFO with count, full, empty. Arbitration, starvation and scoreboard stay in wb_arbiter.

Test Plan:
- Reset then idle -> wren_o=0, slow_ready_o=1 from the first cycle after release, hazard_o=0, all pending=0.
- alu_valid_i=1, rd=5, data=0xDEADBEEF -> same cycle wren_o=1, rd_o=5, datord_o=0xDEADBEEF, wb_stall_o=0. Repeat with rd=0 -> wren_o=0.
- issue_i rd=7; decode rs1=7 -> hazard_o=1. Then slow result rd=7, data=0x12 with no ALU traffic -> next cycle wren_o=1, rd_o=7, data 0x12; following cycle hazard_o=0.
- Push 2 slow results with continuous ALU traffic -> slow_ready_o=0 after the 2nd push. Head is blocked 4 cycles, then in the 5th cycle wb_stall_o=1 and the head writes. The ALU value held upstream writes in the next cycle.
- Issue rd=9 and pop a queued rd=9 in the same cycle -> pending[9] remains 1; hazard_o=1 for rs2=9.
- Assert rst_i with 2 queued entries and pending[3]=1 -> next cycle queue empty, no wren_o for the dropped entries, hazard_o=0 for rs1=3.

Source files
------------

// File: rtl/lagarto_pkg.sv
// Shared writeback types and constants for the Lagarto register-file write path.
package lagarto_pkg;

    localparam int XLEN           = 32;
    localparam int REG_AW         = 5;
    localparam int NREG           = 32;
    localparam int QDEPTH_DEF     = 2;
    localparam int STARVE_MAX_DEF = 4;

    localparam logic [REG_AW-1:0] X0 = '0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO with occupancy count; pushes when full and pops when empty are ignored.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full_o  = (count == CW'(DEPTH));
    assign empty_o = (count == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port owner: merges ALU and queued long-latency results,
// prevents queue starvation, and tracks pending destinations for decode hazards.
module wb_arbiter
    import lagarto_pkg::*;
#(
    parameter int QDEPTH     = QDEPTH_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              alu_valid_i,
    input  logic [REG_AW-1:0] alu_rd_i,
    input  logic [XLEN-1:0]   alu_data_i,
    output logic              wb_stall_o,
    input  logic              slow_valid_i,
    input  logic [REG_AW-1:0] slow_rd_i,
    input  logic [XLEN-1:0]   slow_data_i,
    output logic              slow_ready_o,
    input  logic              issue_i,
    input  logic [REG_AW-1:0] issue_rd_i,
    input  logic [REG_AW-1:0] dec_rs1_i,
    input  logic [REG_AW-1:0] dec_rs2_i,
    input  logic [REG_AW-1:0] dec_rd_i,
    output logic              hazard_o,
    output logic [REG_AW-1:0] rd_o,
    output logic [XLEN-1:0]   datord_o,
    output logic              wren_o
);

    localparam int CNT_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;

    wb_entry_t        slow_in;
    wb_entry_t        q_head;
    logic             q_full;
    logic             q_empty;
    logic             q_push;
    logic             q_pop;
    logic             force_q;
    logic [CNT_W-1:0] starve_cnt;
    logic [NREG-1:0]  pending_q;
    logic [NREG-1:0]  pending_d;

    assign slow_in      = '{rd: slow_rd_i, data: slow_data_i};
    // Ready is withheld when full even if the head pops this cycle.
    assign slow_ready_o = !rst_i && !q_full;
    assign q_push       = slow_valid_i && slow_ready_o;

    wb_fifo #(
        .DEPTH (QDEPTH),
        .W     ($bits(wb_entry_t))
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (q_push),
        .wdata_i (slow_in),
        .pop_i   (q_pop),
        .rdata_o (q_head),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    always_comb begin
        q_pop      = 1'b0;
        wb_stall_o = 1'b0;
        wren_o     = 1'b0;
        rd_o       = X0;
        datord_o   = '0;
        if (!rst_i) begin
            if (force_q && !q_empty) begin
                q_pop      = 1'b1;
                wb_stall_o = alu_valid_i;
                rd_o       = q_head.rd;
                datord_o   = q_head.data;
                wren_o     = (q_head.rd != X0);
            end else if (alu_valid_i) begin
                rd_o     = alu_rd_i;
                datord_o = alu_data_i;
                wren_o   = (alu_rd_i != X0);
            end else if (!q_empty) begin
                q_pop    = 1'b1;
                rd_o     = q_head.rd;
                datord_o = q_head.data;
                wren_o   = (q_head.rd != X0);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt <= '0;
            force_q    <= 1'b0;
        end else if (q_empty || q_pop) begin
            starve_cnt <= '0;
            force_q    <= 1'b0;
        end else if (starve_cnt == CNT_W'(STARVE_MAX - 1)) begin
            force_q <= 1'b1;
        end else begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Clear before set so a same-cycle re-issue keeps the register pending.
    always_comb begin
        pending_d = pending_q;
        if (q_pop && q_head.rd != X0) begin
            pending_d[q_head.rd] = 1'b0;
        end
        if (issue_i && issue_rd_i != X0) begin
            pending_d[issue_rd_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign hazard_o = !rst_i && (
                          (dec_rs1_i != X0 && pending_q[dec_rs1_i]) ||
                          (dec_rs2_i != X0 && pending_q[dec_rs2_i]) ||
                          (dec_rd_i  != X0 && pending_q[dec_rd_i]));

endmodule
